i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- Synthesizable I2C target (responder) with a small byte-wide register file; the responding end of the SoC's I2C initiator.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain; board or bench pullups provide the high level.
- Used in simulation as the device under the SoC I2C bus, and on FPGA as a loopback target.
- Supports pointer-addressed write bursts and read bursts with pointer auto-increment; no clock stretching.

Parameters:
- TARGET_ADDR, 7'h55, 7-bit target address (8'hAA in 8-bit write form).
- NUM_REGS, 4, register count; power of two, 2..256; PW = $clog2(NUM_REGS).

Ports:
- clk  in  1  system clock; must be at least 10x SCL frequency.
- rstn  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- regs_o  out  8*NUM_REGS  register file, reg k at bits [8k+7:8k].
- wr_stb  out  1  one-cycle pulse when a data byte is written.
- wr_ptr  out  PW  register index of the write.
- wr_data  out  8  byte written.
- busy  out  1  high from an address match until STOP, NACK-end, or a non-matching restart.

Behaviour:
- Reset values: sda_oe=0, regs_o=0, wr_stb=0, wr_ptr=0, wr_data=0, busy=0, pointer=0, state IDLE. Reset mid-transfer releases SDA immediately, without waiting for a clock edge.
- Input sync: scl_i and sda_i each pass through 2 flops, plus a 3rd flop for edge detection. Bus events are seen 2-3 clk after the pins change.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high. Both are detected in every state. Data changes while SCL is high are never mistaken for data bits.
- Bit timing: bits are MSB first, sampled on the synced SCL rising edge. sda_oe changes only on the synced SCL falling edge (or on STOP/reset).
- A 3-bit counter counts 8 bits, then a 9th (ACK) slot.

State machine:
- IDLE: sda_oe=0. START -> ADDR.
- ADDR: shift in 8 bits.
  - If byte[7:1]==TARGET_ADDR: on the next SCL fall assert sda_oe (ACK) and set busy.
  - Else -> IDLE, no ACK.
  - R/W=0 -> PTR_ACK path. R/W=1 -> RD path.
- ADDR_ACK / PTR_ACK / WR_ACK: sda_oe=1 from the SCL fall after bit 8 until the SCL fall after the 9th clock.
- PTR: first byte after a write address. pointer = byte[PW-1:0]; upper bits are ignored. ACK it. -> WR.
- WR: shift in a byte. At the 8th rising edge, in one cycle:
  - regs[pointer] = byte
  - wr_stb=1, wr_ptr=pointer, wr_data=byte
  - pointer = pointer+1, wrapping mod NUM_REGS (NUM_REGS-1 -> 0)
  - then ACK. Every write byte is ACKed.
- RD: on the SCL fall ending the ACK slot, load the shift register with regs[pointer] and drive the MSB (sda_oe = ~bit). Shift out on each following fall. After 8 bits, release SDA for the initiator's ACK slot.
- RD_ACK: sample SDA at the 9th rising edge.
  - 0 (ACK): pointer+1 with wrap, reload, continue RD.
  - 1 (NACK): -> WAIT; SDA released, busy=0.
- WAIT: ignore bits until START (-> ADDR) or STOP (-> IDLE).
- Repeated START in any state: -> ADDR, bit counter cleared, pointer preserved. This is how a write-pointer-then-read transfer works.
- STOP in any state: -> IDLE, sda_oe=0 within 3 clk, busy=0. A partially received byte is discarded, with no write.
- Simultaneous START and bit sample on the same cycle: START wins.

Test Plan:
- Write 0xAA, 0x01, 0x5A, 0xC3, STOP -> ACK on all 4 bytes. wr_stb pulses twice: (ptr 1, 0x5A), then (ptr 2, 0xC3). regs_o = 0x00C35A00. busy falls after STOP.
- Write pointer 0x03, then repeated START, 0xAB, read 3 bytes with ACK, ACK, NACK -> returns regs[3], regs[0], regs[1]; pointer wraps from 3 to 0; SDA is released after the NACK.
- Address 0xA8 followed by 3 bytes -> no ACK (SDA stays high in every 9th slot), no wr_stb, busy stays 0, regs_o unchanged.
- STOP issued after 4 data bits of a write byte -> no wr_stb, regs unchanged, state returns to IDLE, sda_oe=0.
- Assert rstn=0 while sda_oe=1 during an ACK slot -> sda_oe=0 immediately; regs_o=0; the next valid transfer completes normally.
- Write pointer 0xFF with NUM_REGS=4 -> pointer=3. A following write of 0x11 updates reg 3 only; a second write of 0x22 updates reg 0.

Source files
------------

// File: rtl/i2c_target_regs.sv
// i2c_target_regs
//   I2C target (responder) with a small byte-wide register file. SCL/SDA are
//   oversampled on clk and SDA is driven open-drain; external pullups provide
//   the high level. A write transfer carries a register pointer byte followed
//   by data bytes. A read transfer returns registers starting at the pointer.
//   The pointer auto-increments and wraps modulo NUM_REGS. There is no clock
//   stretching.
//
// Parameters
//   TARGET_ADDR  7-bit bus address this target answers to
//   NUM_REGS     register count, power of two in 2..256
//
// Ports
//   clk      system clock, at least 10x the SCL frequency
//   rstn     asynchronous active-low reset
//   scl_i    SCL pad input (asynchronous)
//   sda_i    SDA pad input (asynchronous)
//   sda_oe   1 = pull SDA low, 0 = release SDA
//   regs_o   register file, reg k at bits [8k+7:8k]
//   wr_stb   one-cycle pulse when a data byte is written
//   wr_ptr   register index of that write
//   wr_data  byte written
//   busy     high from an address match until STOP, NACK-end or a
//            non-matching restart
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h55,
  parameter int         NUM_REGS    = 4,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_stb,
  output logic [PW-1:0]         wr_ptr,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR,
    S_WR_ACK,
    S_RD,
    S_RD_ACK,
    S_WAIT
  } state_t;

  logic [2:0]    scl_sync;
  logic [2:0]    sda_sync;
  logic          scl_s;
  logic          scl_p;
  logic          sda_s;
  logic          sda_p;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    bit_cnt_q;
  logic [2:0]    bit_cnt_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          ack_phase_q;
  logic          ack_phase_d;
  logic          rd_load_q;
  logic          rd_load_d;
  logic          rw_q;
  logic          rw_d;
  logic          sda_oe_d;
  logic          busy_d;
  logic          wr_stb_d;
  logic [PW-1:0] wr_ptr_d;
  logic [7:0]    wr_data_d;
  logic          mem_we;

  logic [7:0]    mem_q [NUM_REGS];
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;
  logic          addr_match;

  // Synchronizers reset to 1 (idle bus level) so leaving reset never looks
  // like a START, STOP or SCL edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_i};
      sda_sync <= {sda_sync[1:0], sda_i};
    end
  end

  assign scl_s     = scl_sync[1];
  assign scl_p     = scl_sync[2];
  assign sda_s     = sda_sync[1];
  assign sda_p     = sda_sync[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  // START/STOP need SCL high on both sides of the SDA edge, so an SDA change
  // coinciding with an SCL edge is never taken as a bus condition.
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  assign rx_byte    = {shift_q[6:0], sda_s};
  assign rd_byte    = mem_q[ptr_q];
  assign addr_match = (rx_byte[7:1] == TARGET_ADDR);

  // State and protocol registers. The async reset releases SDA at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      ack_phase_q <= 1'b0;
      rd_load_q   <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_stb      <= 1'b0;
      wr_ptr      <= '0;
      wr_data     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      ack_phase_q <= ack_phase_d;
      rd_load_q   <= rd_load_d;
      rw_q        <= rw_d;
      sda_oe      <= sda_oe_d;
      busy        <= busy_d;
      wr_stb      <= wr_stb_d;
      wr_ptr      <= wr_ptr_d;
      wr_data     <= wr_data_d;
    end
  end

  // Register file, written on the 8th SCL rise of each data byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        mem_q[k] <= '0;
      end
    end else if (mem_we) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[8*g +: 8] = mem_q[g];
  end

  // Next-state logic. STOP beats START, and both beat bit handling, so a
  // START landing on the same cycle as a bit sample always wins.
  // ACK slots use ack_phase: the first SCL fall starts driving the ACK and the
  // second fall ends the slot. In a read, shift_q holds the bits still to be
  // sent, and sda_oe always carries the inverted current bit.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    ack_phase_d = ack_phase_q;
    rd_load_d   = rd_load_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe;
    busy_d      = busy;
    wr_stb_d    = 1'b0;
    wr_ptr_d    = wr_ptr;
    wr_data_d   = wr_data;
    mem_we      = 1'b0;

    if (stop_det) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
      rd_load_d   = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (start_det) begin
      state_d     = S_ADDR;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
      rd_load_d   = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_WAIT: begin
        end

        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (addr_match) begin
                state_d     = S_ADDR_ACK;
                rw_d        = sda_s;
                ack_phase_d = 1'b0;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              busy_d      = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              bit_cnt_d   = '0;
              if (rw_q) begin
                state_d  = S_RD;
                shift_d  = {rd_byte[6:0], 1'b0};
                sda_oe_d = ~rd_byte[7];
              end else begin
                state_d  = S_PTR;
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        S_PTR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d       = rx_byte[PW-1:0];
              state_d     = S_PTR_ACK;
              ack_phase_d = 1'b0;
            end
          end
        end

        S_WR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              mem_we      = 1'b1;
              wr_stb_d    = 1'b1;
              wr_ptr_d    = ptr_q;
              wr_data_d   = rx_byte;
              ptr_d       = ptr_q + PW'(1);
              state_d     = S_WR_ACK;
              ack_phase_d = 1'b0;
            end
          end
        end

        S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              bit_cnt_d   = '0;
              state_d     = S_WR;
            end
          end
        end

        S_RD: begin
          if (scl_fall) begin
            if (rd_load_q) begin
              rd_load_d = 1'b0;
              bit_cnt_d = '0;
              shift_d   = {rd_byte[6:0], 1'b0};
              sda_oe_d  = ~rd_byte[7];
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end else if (scl_rise && !rd_load_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d     = S_RD_ACK;
              ack_phase_d = 1'b0;
            end
          end
        end

        S_RD_ACK: begin
          if (scl_fall && !ack_phase_q) begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b1;
          end else if (scl_rise && ack_phase_q) begin
            ack_phase_d = 1'b0;
            if (!sda_s) begin
              ptr_d     = ptr_q + PW'(1);
              rd_load_d = 1'b1;
              state_d   = S_RD;
            end else begin
              state_d = S_WAIT;
              busy_d  = 1'b0;
            end
          end
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs
//   Self-checking bench for i2c_target_regs. A bus initiator made of tasks
//   drives SCL/SDA, and SDA is modelled as a wired-AND with a pullup. A
//   register/pointer model produces expected values. Expected writes are
//   queued as bytes are sent and popped by a wr_stb monitor. Expected read
//   bytes are queued before each read and popped when the byte arrives.
module tb_i2c_target_regs;

  localparam int NUM_REGS = 4;
  localparam int PW       = 2;
  localparam int Q        = 50;

  typedef struct packed {
    logic [PW-1:0] ptr;
    logic [7:0]    data;
  } wr_exp_t;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  scl_drv;
  logic                  sda_drv;
  logic                  sda_line;
  logic                  sda_oe;
  logic [8*NUM_REGS-1:0] regs_o;
  logic                  wr_stb;
  logic [PW-1:0]         wr_ptr;
  logic [7:0]            wr_data;
  logic                  busy;

  wr_exp_t               wr_q [$];
  logic [7:0]            rd_q [$];
  wr_exp_t               mon_exp;
  int                    tests_run = 0;
  int                    fails     = 0;
  logic [7:0]            model_regs [NUM_REGS];
  logic [PW-1:0]         model_ptr;

  assign sda_line = sda_oe ? 1'b0 : sda_drv;

  i2c_target_regs #(
    .TARGET_ADDR (7'h55),
    .NUM_REGS    (NUM_REGS)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .scl_i   (scl_drv),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .regs_o  (regs_o),
    .wr_stb  (wr_stb),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn === 1'b1 && wr_stb === 1'b1) begin
      tests_run++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL wr_stb_unexpected: got ptr=%0d data=%02h, required no write", wr_ptr, wr_data);
      end else begin
        mon_exp = wr_q.pop_front();
        if ({wr_ptr, wr_data} !== mon_exp) begin
          fails++;
          $display("[TB] FAIL wr_stb_content: got ptr=%0d data=%02h, required ptr=%0d data=%02h",
                   wr_ptr, wr_data, mon_exp.ptr, mon_exp.data);
        end
      end
    end
  end

  function automatic logic [8*NUM_REGS-1:0] model_image();
    logic [8*NUM_REGS-1:0] img;
    for (int k = 0; k < NUM_REGS; k++) img[8*k +: 8] = model_regs[k];
    return img;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    model_ptr = '0;
  endfunction

  function automatic void expect_write(input logic [7:0] d);
    wr_q.push_back({model_ptr, d});
    model_regs[model_ptr] = d;
    model_ptr = model_ptr + 1'b1;
  endfunction

  // Bus initiator primitives. SDA only changes while SCL is low, except
  // inside START and STOP.
  task automatic bus_start();
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b1; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    sda_drv = b;    #Q;
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    acked = (sda_line === 1'b0);
    #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      sda_drv = 1'b1; #Q;
      scl_drv = 1'b1; #Q;
      d = {d[6:0], sda_line};
      #Q;
      scl_drv = 1'b0; #Q;
    end
    put_bit(nack);
  endtask

  task automatic test_reset();
    rstn = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
    model_reset();
    #100;
    rstn = 1'b1;
    #20;
    tests_run++; if (sda_oe !== 1'b0) begin fails++; $display("[TB] FAIL reset_sda_oe: got %b, required 0", sda_oe); end
    tests_run++; if (regs_o !== '0) begin fails++; $display("[TB] FAIL reset_regs: got %h, required 0", regs_o); end
    tests_run++; if (wr_stb !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_stb: got %b, required 0", wr_stb); end
    tests_run++; if (wr_ptr !== '0) begin fails++; $display("[TB] FAIL reset_wr_ptr: got %0d, required 0", wr_ptr); end
    tests_run++; if (wr_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_wr_data: got %h, required 00", wr_data); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_write_burst();
    logic       ack;
    logic [7:0] data [2];
    data = '{8'h5A, 8'hC3};
    bus_start();
    send_byte(8'hAA, ack);
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL wb_addr_ack: got %b, required 1", ack); end
    tests_run++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL wb_busy: got %b, required 1", busy); end
    send_byte(8'h01, ack);
    model_ptr = 2'd1;
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL wb_ptr_ack: got %b, required 1", ack); end
    for (int i = 0; i < 2; i++) begin
      expect_write(data[i]);
      send_byte(data[i], ack);
      tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL wb_data_ack: byte %0d got %b, required 1", i, ack); end
    end
    bus_stop();
    tests_run++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL wb_busy_after_stop: got %b, required 0", busy); end
    tests_run++; if (sda_oe !== 1'b0) begin fails++; $display("[TB] FAIL wb_sda_oe_after_stop: got %b, required 0", sda_oe); end
    tests_run++; if (regs_o !== 32'h00C35A00) begin fails++; $display("[TB] FAIL wb_regs: got %h, required 00c35a00", regs_o); end
    tests_run++; if (wr_q.size() != 0) begin fails++; $display("[TB] FAIL wb_writes_seen: got %0d pending, required 0", wr_q.size()); end
  endtask

  task automatic test_wrong_addr();
    logic       ack;
    logic [7:0] seq [4];
    seq = '{8'hA8, 8'h12, 8'h34, 8'h56};
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i], ack);
      tests_run++; if (ack !== 1'b0) begin fails++; $display("[TB] FAIL wa_no_ack: byte %0d got %b, required 0", i, ack); end
      tests_run++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL wa_busy: byte %0d got %b, required 0", i, busy); end
    end
    bus_stop();
    tests_run++; if (regs_o !== model_image()) begin fails++; $display("[TB] FAIL wa_regs: got %h, required %h", regs_o, model_image()); end
  endtask

  task automatic test_ptr_wrap();
    logic ack;
    bus_start();
    send_byte(8'hAA, ack);
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL pw_addr_ack: got %b, required 1", ack); end
    send_byte(8'hFF, ack);
    model_ptr = 2'd3;
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL pw_ptr_ack: got %b, required 1", ack); end
    expect_write(8'h11);
    send_byte(8'h11, ack);
    tests_run++; if (regs_o !== 32'h11C35A00) begin fails++; $display("[TB] FAIL pw_reg3: got %h, required 11c35a00", regs_o); end
    expect_write(8'h22);
    send_byte(8'h22, ack);
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL pw_data_ack: got %b, required 1", ack); end
    tests_run++; if (regs_o !== 32'h11C35A22) begin fails++; $display("[TB] FAIL pw_reg0: got %h, required 11c35a22", regs_o); end
    bus_stop();
    tests_run++; if (wr_q.size() != 0) begin fails++; $display("[TB] FAIL pw_writes_seen: got %0d pending, required 0", wr_q.size()); end
  endtask

  task automatic test_ptr_then_read();
    logic       ack;
    logic [7:0] got;
    logic [7:0] exp;
    bus_start();
    send_byte(8'hAA, ack);
    send_byte(8'h03, ack);
    model_ptr = 2'd3;
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL rd_ptr_ack: got %b, required 1", ack); end
    bus_start();
    send_byte(8'hAB, ack);
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL rd_addr_ack: got %b, required 1", ack); end
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(model_regs[model_ptr]);
      if (i < 2) model_ptr = model_ptr + 1'b1;
      recv_byte(i == 2, got);
      exp = rd_q.pop_front();
      tests_run++; if (got !== exp) begin fails++; $display("[TB] FAIL rd_data: byte %0d got %h, required %h", i, got, exp); end
    end
    tests_run++; if (sda_oe !== 1'b0) begin fails++; $display("[TB] FAIL rd_release_after_nack: got %b, required 0", sda_oe); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rd_busy_after_nack: got %b, required 0", busy); end
    bus_stop();
  endtask

  task automatic test_stop_mid_byte();
    logic ack;
    bus_start();
    send_byte(8'hAA, ack);
    send_byte(8'h02, ack);
    model_ptr = 2'd2;
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    bus_stop();
    tests_run++; if (sda_oe !== 1'b0) begin fails++; $display("[TB] FAIL smb_sda_oe: got %b, required 0", sda_oe); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL smb_busy: got %b, required 0", busy); end
    tests_run++; if (regs_o !== model_image()) begin fails++; $display("[TB] FAIL smb_regs: got %h, required %h", regs_o, model_image()); end
  endtask

  task automatic test_reset_mid_ack();
    logic       ack;
    logic [7:0] addr;
    addr = 8'hAA;
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(addr[i]);
    tests_run++; if (sda_oe !== 1'b1) begin fails++; $display("[TB] FAIL rma_ack_driven: got %b, required 1", sda_oe); end
    rstn = 1'b0;
    model_reset();
    #1;
    tests_run++; if (sda_oe !== 1'b0) begin fails++; $display("[TB] FAIL rma_sda_release: got %b, required 0", sda_oe); end
    tests_run++; if (regs_o !== '0) begin fails++; $display("[TB] FAIL rma_regs: got %h, required 0", regs_o); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rma_busy: got %b, required 0", busy); end
    sda_drv = 1'b1;
    #(Q-1);
    rstn = 1'b1;
    #Q;
    bus_stop();
    bus_start();
    send_byte(8'hAA, ack);
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL rma_post_addr_ack: got %b, required 1", ack); end
    send_byte(8'h00, ack);
    model_ptr = 2'd0;
    expect_write(8'h77);
    send_byte(8'h77, ack);
    tests_run++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL rma_post_data_ack: got %b, required 1", ack); end
    bus_stop();
    tests_run++; if (regs_o !== 32'h00000077) begin fails++; $display("[TB] FAIL rma_post_regs: got %h, required 00000077", regs_o); end
    tests_run++; if (wr_q.size() != 0) begin fails++; $display("[TB] FAIL rma_writes_seen: got %0d pending, required 0", wr_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_wrong_addr();
    test_ptr_wrap();
    test_ptr_then_read();
    test_stop_mid_byte();
    test_reset_mid_ack();
    #100;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
